// File: rtl/simd_writeback_unit.sv
// Execute-stage writeback: result FIFO plus one output register driving the vector RF write port.
// Optional macro SIMD_WB_BYPASS_EN lets a result skip the empty FIFO straight into the output register.

module simd_wb_lane #(
   parameter int DATA_WIDTH = 32,
   parameter int LANE       = 0
) (
   input  logic                  sel_dot,
   input  logic [DATA_WIDTH-1:0] elem,
   input  logic [DATA_WIDTH-1:0] dot,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  mask
);
   // Dot products carry their scalar in lane 0 only; the other lanes are zeroed and masked off
   assign data = sel_dot ? ((LANE == 0) ? dot : '0) : elem;
   assign mask = (LANE == 0) ? 1'b1 : ~sel_dot;
endmodule

module simd_writeback_unit #(
   parameter int PE_COUNT       = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           in_sel_dot,
   input  logic [REG_ADDR_WIDTH-1:0]      in_dest,
   input  logic [PE_COUNT*DATA_WIDTH-1:0] elem_in,
   input  logic [PE_COUNT*DATA_WIDTH-1:0] dot_in,
   input  logic                           flush,
   output logic                           rf_we,
   input  logic                           rf_ready,
   output logic [REG_ADDR_WIDTH-1:0]      rf_waddr,
   output logic [PE_COUNT*DATA_WIDTH-1:0] rf_wdata,
   output logic [PE_COUNT-1:0]            rf_wmask,
   output logic                           busy,
   output logic [15:0]                    wb_count
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0]      dest;
      logic [PE_COUNT*DATA_WIDTH-1:0] data;
      logic [PE_COUNT-1:0]            mask;
   } entry_t;

   typedef enum logic {IDLE, WRITE} state_t;

   state_t                         state;
   entry_t                         mem [FIFO_DEPTH];
   entry_t                         in_entry;
   logic [PW-1:0]                  wr_ptr, rd_ptr;
   logic [CW-1:0]                  count;
   logic [PE_COUNT*DATA_WIDTH-1:0] fmt_data;
   logic [PE_COUNT-1:0]            fmt_mask;
   logic                           push, pop, fifo_push, bypass, out_free;

   for (genvar i = 0; i < PE_COUNT; i++) begin : g_lane
      simd_wb_lane #(.DATA_WIDTH(DATA_WIDTH), .LANE(i)) u_lane (
         .sel_dot (in_sel_dot),
         .elem    (elem_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .dot     (dot_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .data    (fmt_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .mask    (fmt_mask[i])
      );
   end

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_entry  = {in_dest, fmt_data, fmt_mask};
   assign in_ready  = rstn & ~flush & (count < CW'(FIFO_DEPTH));
   assign push      = in_valid & in_ready;
   // Output register can take a new entry when empty or when its write retires this edge
   assign out_free  = (state == IDLE) | rf_ready;
   assign pop       = ~flush & (count != '0) & out_free;
`ifdef SIMD_WB_BYPASS_EN
   assign bypass    = push & (count == '0) & out_free;
`else
   assign bypass    = 1'b0;
`endif
   assign fifo_push = push & ~bypass;
   assign rf_we     = (state == WRITE);
   assign busy      = (count != '0) | rf_we;

   always_ff @(posedge clk) begin
      if (fifo_push) mem[wr_ptr] <= in_entry;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (fifo_push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)       rd_ptr <= ptr_next(rd_ptr);
         if (fifo_push && !pop)      count <= count + 1'b1;
         else if (!fifo_push && pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         rf_waddr <= '0;
         rf_wdata <= '0;
         rf_wmask <= '0;
         wb_count <= '0;
      end else begin
         if (state == WRITE && rf_ready) wb_count <= wb_count + 16'd1;
         if (pop) begin
            state                          <= WRITE;
            {rf_waddr, rf_wdata, rf_wmask} <= mem[rd_ptr];
         end else if (bypass) begin
            state                          <= WRITE;
            {rf_waddr, rf_wdata, rf_wmask} <= in_entry;
         end else if (out_free) begin
            state <= IDLE;
         end
      end
   end
endmodule
